// File: rtl/load_data_formatter.sv
// Load-path result formatter. Queues per-load metadata at issue, pairs
// each returned raw word with the head entry, then extracts, aligns and
// sign/zero-extends it onto a registered writeback handshake.
module load_data_formatter #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [1:0]                 issue_byte_off,
  input  logic [2:0]                 issue_fn3,
  input  logic [ID_W-1:0]            issue_id,
  input  logic                       raw_valid,
  input  logic [31:0]                raw_data,
  output logic                       raw_ack,
  output logic                       wb_valid,
  output logic [31:0]                wb_data,
  output logic [ID_W-1:0]            wb_id,
  input  logic                       wb_ack,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic                       protocol_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]      r_off [DEPTH];
  logic [2:0]      r_fn3 [DEPTH];
  logic [ID_W-1:0] r_id  [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_wb_valid;
  logic [31:0]     r_wb_data;
  logic [ID_W-1:0] r_wb_id;
  logic            r_perr;

  logic            w_full, w_empty, w_push, w_pop;
  logic [1:0]      w_head_off;
  logic [2:0]      w_head_fn3;
  logic [ID_W-1:0] w_head_id;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_fmt;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = issue_valid & ~w_full;
  // Output slot is free when empty or being drained this cycle.
  assign w_pop      = raw_valid & ~w_empty & (~r_wb_valid | wb_ack);
  assign w_head_off = r_off[r_rd_ptr];
  assign w_head_fn3 = r_fn3[r_rd_ptr];
  assign w_head_id  = r_id[r_rd_ptr];

  assign issue_ready  = ~w_full;
  assign raw_ack      = w_pop;
  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_id        = r_wb_id;
  assign inflight     = r_count;
  assign protocol_err = r_perr;

  // Metadata storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_off[r_wr_ptr] <= issue_byte_off;
      r_fn3[r_wr_ptr] <= issue_fn3;
      r_id[r_wr_ptr]  <= issue_id;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Extract and extend the addressed byte/half; LW and reserved fn3 pass through.
  always_comb begin
    w_byte = raw_data[{w_head_off, 3'b000} +: 8];
    w_half = raw_data[{w_head_off[1], 4'b0000} +: 16];
    w_fmt  = raw_data;
    case (w_head_fn3)
      3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_fmt = {24'h0, w_byte};
      3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
      3'b101:  w_fmt = {16'h0, w_half};
      default: w_fmt = raw_data;
    endcase
  end

  // Writeback register: load on ack of a raw word, else drain on wb_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_id    <= '0;
    end else if (w_pop) begin
      r_wb_valid <= 1'b1;
      r_wb_data  <= w_fmt;
      r_wb_id    <= w_head_id;
    end else if (wb_ack) begin
      r_wb_valid <= 1'b0;
    end
  end

  // Sticky protocol error: word with nothing queued, or push while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_perr <= 1'b0;
    else if ((raw_valid & w_empty) | (issue_valid & w_full))
      r_perr <= 1'b1;
  end
endmodule
